// File: rtl/lcd_fill_seq.sv
// lcd_fill_seq: LCD window preamble plus solid-colour frame word sequencer (optional timeout: LCD_SEQ_TIMEOUT_EN)
module lcd_fill_seq #(
    parameter int H_PIX   = 240,
    parameter int V_PIX   = 320,
    parameter int TIMEOUT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [15:0] i_color,
    input  logic        i_done,
    output logic [15:0] o_data,
    output logic        o_we,
    output logic        o_dc,
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_err
);
    localparam int NPIX = H_PIX * V_PIX;
    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
    state_t        state;
    logic [2:0]    idx;
    logic [PW-1:0] pix;
    logic [15:0]   color;
    logic [2:0]    nidx;
    logic [16:0]   nword;
    logic          last;
`ifdef LCD_SEQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wcnt;
`else
    assign o_err = 1'b0;
`endif
    // idx 7 marks the pixel phase; next word is {dc, data} for the word after the current one
    always_comb begin
        nidx  = (idx == 3'd7) ? 3'd7 : idx + 3'd1;
        nword = (nidx == 3'd1 || nidx == 3'd4) ? {1'b1, 16'h0000} :
                (nidx == 3'd2) ? {1'b1, 16'(H_PIX - 1)} :
                (nidx == 3'd3) ? {1'b0, 16'h002B} :
                (nidx == 3'd5) ? {1'b1, 16'(V_PIX - 1)} :
                (nidx == 3'd6) ? {1'b0, 16'h002C} : {1'b1, color};
        last  = (idx == 3'd7) && (pix == LAST_PIX);
    end
    // sequencer FSM with registered word, strobe and status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            idx          <= 3'd0;
            pix          <= '0;
            color        <= 16'h0000;
            o_data       <= 16'h0000;
            o_we         <= 1'b0;
            o_dc         <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
            wcnt         <= '0;
            o_err        <= 1'b0;
`endif
        end else begin
            o_we         <= 1'b0;
            o_frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= ISSUE;
                        color  <= i_color;
                        idx    <= 3'd0;
                        pix    <= '0;
                        o_data <= 16'h002A;
                        o_dc   <= 1'b0;
                        o_we   <= 1'b1;
                        o_busy <= 1'b1;
`ifdef LCD_SEQ_TIMEOUT_EN
                        o_err  <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    state <= WAIT;
`ifdef LCD_SEQ_TIMEOUT_EN
                    wcnt  <= '0;
`endif
                end
                WAIT: begin
                    if (i_done) begin
                        if (last) begin
                            state        <= FINISH;
                            o_frame_done <= 1'b1;
                        end else begin
                            state          <= ISSUE;
                            idx            <= nidx;
                            pix            <= (idx == 3'd7) ? pix + 1'b1 : pix;
                            {o_dc, o_data} <= nword;
                            o_we           <= 1'b1;
                        end
                    end
`ifdef LCD_SEQ_TIMEOUT_EN
                    else if (wcnt == TO_LAST) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_err  <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
`endif
                end
                FINISH: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_fill_seq.sv
// tb_lcd_fill_seq: directed checks of the frame word sequence, pacing, start/done filtering, reset and timeout
module tb_lcd_fill_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_color;
    logic        i_done;
    logic [15:0] o_data;
    logic        o_we;
    logic        o_dc;
    logic        o_busy;
    logic        o_frame_done;
    logic        o_err;
    int          ncmp = 0;
    int          nfail = 0;
    int          we_cnt = 0;
    int          fd_cnt = 0;
    int          w0;
    int          f0;

    lcd_fill_seq #(.H_PIX(4), .V_PIX(2), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start), .i_color(i_color), .i_done(i_done),
        .o_data(o_data), .o_we(o_we), .o_dc(o_dc), .o_busy(o_busy),
        .o_frame_done(o_frame_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_we === 1'b1) we_cnt++;
        if (o_frame_done === 1'b1) fd_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] exp_word(input int i, input logic [15:0] col);
        logic [16:0] pre [7] = '{17'h0002A, 17'h10000, 17'h10003, 17'h0002B,
                                 17'h10000, 17'h10001, 17'h0002C};
        return (i < 7) ? pre[i] : {1'b1, col};
    endfunction

    task automatic start(input logic [15:0] col);
        i_start = 1'b1;
        i_color = col;
        step();
        i_start = 1'b0;
        i_color = 16'h5A5A;
        chk("start_busy", {31'd0, o_busy}, 32'd1);
    endtask

    // called in the o_we cycle; ends in the cycle right after i_done
    task automatic serve(input logic [16:0] exp, input int d, input bit stray, input bit poke);
        bit ok = 1'b1;
        chk("we_after_done", {31'd0, o_we}, 32'd1);
        chk("word", {15'd0, o_dc, o_data}, {15'd0, exp});
        i_done = stray;
        if (poke) begin
            i_start = 1'b1;
            i_color = 16'h001F;
        end
        for (int k = 1; k <= d; k++) begin
            step();
            i_done  = (k == d);
            i_start = 1'b0;
            ok &= (o_we === 1'b0) && ({o_dc, o_data} === exp) && (o_busy === 1'b1);
        end
        step();
        i_done = 1'b0;
        chk("hold_stable", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_frame(input logic [15:0] col, input int dfix, input int poke_i,
                             input int stray_i, input int stop_i);
        for (int i = 0; i < 15; i++) begin
            if (i == stop_i) return;
            serve(exp_word(i, col), (dfix > 0) ? dfix : int'($urandom_range(1, 50)),
                  i == stray_i, i == poke_i);
        end
        chk("frame_done_pulse", {31'd0, o_frame_done}, 32'd1);
        chk("no_we_after_last", {31'd0, o_we}, 32'd0);
        chk("busy_in_finish", {31'd0, o_busy}, 32'd1);
        step();
        chk("busy_drop", {31'd0, o_busy}, 32'd0);
        chk("frame_done_single", {31'd0, o_frame_done}, 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_done  = 1'b0;
        i_color = 16'h0000;
        step();
        step();
        chk("rst_data", {16'd0, o_data}, 32'd0);
        chk("rst_ctl", {27'd0, o_we, o_dc, o_busy, o_frame_done, o_err}, 32'd0);
        rst_n = 1'b1;
        step();
        i_done = 1'b1;
        step();
        i_done = 1'b0;
        step();
        chk("idle_stray_we", we_cnt, 0);
        chk("idle_stray_busy", {31'd0, o_busy}, 32'd0);

        w0 = we_cnt;
        f0 = fd_cnt;
        start(16'hF800);
        run_frame(16'hF800, 28, 10, -1, -1);
        chk("f1_we_count", we_cnt - w0, 15);
        chk("f1_fd_count", fd_cnt - f0, 1);
        chk("f1_err", {31'd0, o_err}, 32'd0);

        w0 = we_cnt;
        f0 = fd_cnt;
        start(16'h1234);
        run_frame(16'h1234, 0, -1, 0, -1);
        chk("f2_we_count", we_cnt - w0, 15);
        chk("f2_fd_count", fd_cnt - f0, 1);

        start(16'hABCD);
        run_frame(16'hABCD, 3, -1, 7, 12);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_data", {16'd0, o_data}, 32'd0);
        chk("async_rst_ctl", {27'd0, o_we, o_dc, o_busy, o_frame_done, o_err}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", {31'd0, o_busy}, 32'd0);
        w0 = we_cnt;
        f0 = fd_cnt;
        start(16'h07E0);
        run_frame(16'h07E0, 2, -1, -1, -1);
        chk("f4_we_count", we_cnt - w0, 15);
        chk("f4_fd_count", fd_cnt - f0, 1);

`ifdef LCD_SEQ_TIMEOUT_EN
        start(16'h1111);
        serve(exp_word(0, 16'h1111), 3, 1'b0, 1'b0);
        serve(exp_word(1, 16'h1111), 3, 1'b0, 1'b0);
        chk("to_word2", {15'd0, o_dc, o_data}, 32'h10003);
        f0 = fd_cnt;
        repeat (16) step();
        chk("to_err_early", {31'd0, o_err}, 32'd0);
        chk("to_busy_wait", {31'd0, o_busy}, 32'd1);
        step();
        chk("to_err_set", {31'd0, o_err}, 32'd1);
        chk("to_idle", {31'd0, o_busy}, 32'd0);
        repeat (5) step();
        chk("to_no_frame_done", fd_cnt - f0, 0);
        chk("to_err_sticky", {31'd0, o_err}, 32'd1);
        start(16'h2222);
        chk("to_err_cleared", {31'd0, o_err}, 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
